dla_hld_ram_generic_n_way_depth_stitch: RTL and testbench

//  Generalised depth stitch for dla_hld_ram: one logical true-dual-port RAM built from NUM_SECTIONS physical sections of

---
 rtl/dla_hld_ram_stitch_pkg.sv | 39 +++
 rtl/dla_hld_ram_stitch_port.sv | 127 ++++++++++++
 rtl/dla_hld_ram_generic_n_way_depth_stitch.sv | 94 +++++++++
 tb/tb_dla_hld_ram_generic_n_way_depth_stitch.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dla_hld_ram_stitch_pkg.sv
// Shared constants and elaboration-time helpers for the N-way depth stitch.
package dla_hld_ram_stitch_pkg;

  localparam int MAX_SECTIONS = 8;

  typedef int depth_arr_t [MAX_SECTIONS];

  function automatic int stitch_clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int stitch_total_depth(input depth_arr_t d, input int n);
    int t;
    t = 0;
    for (int s = 0; s < n; s++) t += d[s];
    return t;
  endfunction

  function automatic int stitch_base(input depth_arr_t d, input int s);
    int b;
    b = 0;
    for (int i = 0; i < s; i++) b += d[i];
    return b;
  endfunction

  function automatic int stitch_max_addr_width(input depth_arr_t d, input int n);
    int w;
    w = 1;
    for (int s = 0; s < n; s++)
      if (stitch_clog2_min1(d[s]) > w) w = stitch_clog2_min1(d[s]);
    return w;
  endfunction

  // One code beyond the last section index encodes "no section hit".
  function automatic int stitch_sel_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dla_hld_ram_stitch_port.sv
// One logical RAM port: address decode into sections, latency-matched select/valid pipeline,
// readdata mux and sticky out-of-range flag.
module dla_hld_ram_stitch_port
  import dla_hld_ram_stitch_pkg::*;
#(
  parameter int         NUM_SECTIONS      = 4,
  parameter depth_arr_t SECTION_DEPTH     = '{512, 512, 512, 256, 0, 0, 0, 0},
  parameter int         WIDTH             = 32,
  parameter int         REGISTER_ADDRESS  = 1,
  parameter int         REGISTER_READDATA = 1,
  localparam int        DEPTH             = stitch_total_depth(SECTION_DEPTH, NUM_SECTIONS),
  localparam int        ADDR              = stitch_clog2_min1(DEPTH),
  localparam int        SEC_ADDR          = stitch_max_addr_width(SECTION_DEPTH, NUM_SECTIONS),
  localparam int        SEL_W             = stitch_sel_width(NUM_SECTIONS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             error_clear,
  input  logic [ADDR-1:0]                  address,
  input  logic                             read_enable,
  input  logic                             write,
  input  logic                             in_clock_en,
  input  logic                             out_clock_en,
  output logic [NUM_SECTIONS*SEC_ADDR-1:0] sec_address,
  output logic [NUM_SECTIONS-1:0]          sec_read_enable,
  output logic [NUM_SECTIONS-1:0]          sec_write,
  input  logic [NUM_SECTIONS*WIDTH-1:0]    sec_readdata,
  output logic [WIDTH-1:0]                 readdata,
  output logic                             readdata_valid,
  output logic                             oob_error
);

  logic [31:0]             addr_ext;
  logic [NUM_SECTIONS-1:0] hit;
  logic                    vld_p0, oob_p0;
  logic [SEL_W-1:0]        sel_p0;
  logic                    vld_p1, oob_p1;
  logic [SEL_W-1:0]        sel_p1;
  logic                    vld_p2, oob_p2;
  logic [SEL_W-1:0]        sel_p2;

  assign addr_ext = 32'(address);

  // Stage p0: combinational decode. An address below BASE wraps the offset far above any depth.
  for (genvar s = 0; s < NUM_SECTIONS; s++) begin : g_dec
    localparam int BASE = stitch_base(SECTION_DEPTH, s);
    logic [31:0] offset;
    assign offset = addr_ext - 32'(BASE);
    assign sec_address[s*SEC_ADDR +: SEC_ADDR] = SEC_ADDR'(offset);
    if (SECTION_DEPTH[s] == 0) begin : g_empty
      assign hit[s] = 1'b0;
    end else begin : g_live
      assign hit[s] = offset < 32'(SECTION_DEPTH[s]);
    end
    assign sec_write[s]       = write & hit[s];
    assign sec_read_enable[s] = read_enable & hit[s];
  end

  always_comb begin
    sel_p0 = SEL_W'(NUM_SECTIONS);
    for (int s = 0; s < NUM_SECTIONS; s++)
      if (hit[s]) sel_p0 = SEL_W'(s);
  end

  assign vld_p0 = read_enable;
  assign oob_p0 = addr_ext >= 32'(DEPTH);

  // Stage p1: mirrors the physical address register.
  if (REGISTER_ADDRESS != 0) begin : g_addr_reg
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld_p1 <= 1'b0;
        oob_p1 <= 1'b0;
        sel_p1 <= '0;
      end else if (in_clock_en) begin
        vld_p1 <= vld_p0;
        oob_p1 <= oob_p0;
        sel_p1 <= sel_p0;
      end
    end
  end else begin : g_addr_pass
    assign vld_p1 = vld_p0;
    assign oob_p1 = oob_p0;
    assign sel_p1 = sel_p0;
  end

  // Stage p2: mirrors the physical readdata register.
  if (REGISTER_READDATA != 0) begin : g_data_reg
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld_p2 <= 1'b0;
        oob_p2 <= 1'b0;
        sel_p2 <= '0;
      end else if (out_clock_en) begin
        vld_p2 <= vld_p1;
        oob_p2 <= oob_p1;
        sel_p2 <= sel_p1;
      end
    end
  end else begin : g_data_pass
    logic unused_out_clock_en;
    assign unused_out_clock_en = out_clock_en;
    assign vld_p2 = vld_p1;
    assign oob_p2 = oob_p1;
    assign sel_p2 = sel_p1;
  end

  always_comb begin
    readdata = '0;
    if (vld_p2 && !oob_p2)
      for (int s = 0; s < NUM_SECTIONS; s++)
        if (sel_p2 == SEL_W'(s)) readdata = sec_readdata[s*WIDTH +: WIDTH];
  end

  assign readdata_valid = vld_p2;

  // A new out-of-range access outranks a simultaneous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      oob_error <= 1'b0;
    else if (in_clock_en && (write || read_enable) && oob_p0)
      oob_error <= 1'b1;
    else if (error_clear)
      oob_error <= 1'b0;
  end

endmodule

// File: rtl/dla_hld_ram_generic_n_way_depth_stitch.sv
// Logical true-dual-port RAM stitched in depth from NUM_SECTIONS physical sections of arbitrary depth.
// SECTION_DEPTH entries at index >= NUM_SECTIONS are ignored.
module dla_hld_ram_generic_n_way_depth_stitch
  import dla_hld_ram_stitch_pkg::*;
#(
  parameter int         NUM_SECTIONS        = 4,
  parameter depth_arr_t SECTION_DEPTH       = '{512, 512, 512, 256, 0, 0, 0, 0},
  parameter int         WIDTH               = 32,
  parameter int         REGISTER_A_ADDRESS  = 1,
  parameter int         REGISTER_B_ADDRESS  = 1,
  parameter int         REGISTER_A_READDATA = 1,
  parameter int         REGISTER_B_READDATA = 1,
  localparam int        DEPTH               = stitch_total_depth(SECTION_DEPTH, NUM_SECTIONS),
  localparam int        ADDR                = stitch_clog2_min1(DEPTH),
  localparam int        SEC_ADDR            = stitch_max_addr_width(SECTION_DEPTH, NUM_SECTIONS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             error_clear,
  input  logic [ADDR-1:0]                  a_address,
  input  logic                             a_read_enable,
  input  logic                             a_write,
  input  logic                             a_in_clock_en,
  input  logic                             a_out_clock_en,
  output logic [NUM_SECTIONS*SEC_ADDR-1:0] sec_a_address,
  output logic [NUM_SECTIONS-1:0]          sec_a_read_enable,
  output logic [NUM_SECTIONS-1:0]          sec_a_write,
  input  logic [NUM_SECTIONS*WIDTH-1:0]    sec_a_readdata,
  output logic [WIDTH-1:0]                 a_readdata,
  output logic                             a_readdata_valid,
  output logic                             a_oob_error,
  input  logic [ADDR-1:0]                  b_address,
  input  logic                             b_read_enable,
  input  logic                             b_write,
  input  logic                             b_in_clock_en,
  input  logic                             b_out_clock_en,
  output logic [NUM_SECTIONS*SEC_ADDR-1:0] sec_b_address,
  output logic [NUM_SECTIONS-1:0]          sec_b_read_enable,
  output logic [NUM_SECTIONS-1:0]          sec_b_write,
  input  logic [NUM_SECTIONS*WIDTH-1:0]    sec_b_readdata,
  output logic [WIDTH-1:0]                 b_readdata,
  output logic                             b_readdata_valid,
  output logic                             b_oob_error
);

  dla_hld_ram_stitch_port #(
    .NUM_SECTIONS      (NUM_SECTIONS),
    .SECTION_DEPTH     (SECTION_DEPTH),
    .WIDTH             (WIDTH),
    .REGISTER_ADDRESS  (REGISTER_A_ADDRESS),
    .REGISTER_READDATA (REGISTER_A_READDATA)
  ) u_port_a (
    .clock           (clock),
    .reset           (reset),
    .error_clear     (error_clear),
    .address         (a_address),
    .read_enable     (a_read_enable),
    .write           (a_write),
    .in_clock_en     (a_in_clock_en),
    .out_clock_en    (a_out_clock_en),
    .sec_address     (sec_a_address),
    .sec_read_enable (sec_a_read_enable),
    .sec_write       (sec_a_write),
    .sec_readdata    (sec_a_readdata),
    .readdata        (a_readdata),
    .readdata_valid  (a_readdata_valid),
    .oob_error       (a_oob_error)
  );

  dla_hld_ram_stitch_port #(
    .NUM_SECTIONS      (NUM_SECTIONS),
    .SECTION_DEPTH     (SECTION_DEPTH),
    .WIDTH             (WIDTH),
    .REGISTER_ADDRESS  (REGISTER_B_ADDRESS),
    .REGISTER_READDATA (REGISTER_B_READDATA)
  ) u_port_b (
    .clock           (clock),
    .reset           (reset),
    .error_clear     (error_clear),
    .address         (b_address),
    .read_enable     (b_read_enable),
    .write           (b_write),
    .in_clock_en     (b_in_clock_en),
    .out_clock_en    (b_out_clock_en),
    .sec_address     (sec_b_address),
    .sec_read_enable (sec_b_read_enable),
    .sec_write       (sec_b_write),
    .sec_readdata    (sec_b_readdata),
    .readdata        (b_readdata),
    .readdata_valid  (b_readdata_valid),
    .oob_error       (b_oob_error)
  );

endmodule

// File: tb/tb_dla_hld_ram_generic_n_way_depth_stitch.sv
// Bench for the N-way depth stitch: instances with read latency 0, 1 and 2 share one stimulus.
module tb_dla_hld_ram_generic_n_way_depth_stitch;

  localparam int NS = 4, W = 32, AW = 11, SA = 9;
  localparam int SEC_BASE  [NS] = '{0, 512, 1024, 1536};
  localparam int SEC_DEPTH [NS] = '{512, 512, 512, 256};
  localparam int TOTAL = 1792;
  localparam int DUT2 = 2;

  logic clock = 1'b0;
  logic reset, error_clear;
  logic [AW-1:0]   a_address, b_address;
  logic            a_read_enable, a_write, a_in_clock_en, a_out_clock_en;
  logic            b_read_enable, b_write, b_in_clock_en, b_out_clock_en;
  logic [NS*W-1:0] sec_a_readdata, sec_b_readdata;

  logic [NS*SA-1:0] sec_a_address [3], sec_b_address [3];
  logic [NS-1:0]    sec_a_read_enable [3], sec_a_write [3], sec_b_read_enable [3], sec_b_write [3];
  logic [W-1:0]     a_readdata [3], b_readdata [3];
  logic             a_readdata_valid [3], b_readdata_valid [3], a_oob_error [3], b_oob_error [3];

  always #5 clock = ~clock;

  // Instance g has read latency g.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dla_hld_ram_generic_n_way_depth_stitch #(
      .REGISTER_A_ADDRESS  (g >= 1 ? 1 : 0),
      .REGISTER_B_ADDRESS  (g >= 1 ? 1 : 0),
      .REGISTER_A_READDATA (g == 2 ? 1 : 0),
      .REGISTER_B_READDATA (g == 2 ? 1 : 0)
    ) dut (
      .clock (clock), .reset (reset), .error_clear (error_clear),
      .a_address (a_address), .a_read_enable (a_read_enable), .a_write (a_write),
      .a_in_clock_en (a_in_clock_en), .a_out_clock_en (a_out_clock_en),
      .sec_a_address (sec_a_address[g]), .sec_a_read_enable (sec_a_read_enable[g]),
      .sec_a_write (sec_a_write[g]), .sec_a_readdata (sec_a_readdata),
      .a_readdata (a_readdata[g]), .a_readdata_valid (a_readdata_valid[g]), .a_oob_error (a_oob_error[g]),
      .b_address (b_address), .b_read_enable (b_read_enable), .b_write (b_write),
      .b_in_clock_en (b_in_clock_en), .b_out_clock_en (b_out_clock_en),
      .sec_b_address (sec_b_address[g]), .sec_b_read_enable (sec_b_read_enable[g]),
      .sec_b_write (sec_b_write[g]), .sec_b_readdata (sec_b_readdata),
      .b_readdata (b_readdata[g]), .b_readdata_valid (b_readdata_valid[g]), .b_oob_error (b_oob_error[g])
    );
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: a read request remembers which section it targets; the instance with latency L
  // presents the request issued L enabled stage-steps earlier.
  typedef struct packed { logic v; logic oob; logic [3:0] sec; } req_t;
  req_t st_a [3][2];
  req_t st_d [3][2];
  logic err_m [3][2];

  function automatic int section_of(input int addr);
    for (int s = 0; s < NS; s++)
      if (addr >= SEC_BASE[s] && addr < SEC_BASE[s] + SEC_DEPTH[s]) return s;
    return -1;
  endfunction

  function automatic req_t make_req(input int addr, input logic re);
    req_t r;
    int s;
    s = section_of(addr);
    r.v = re;
    r.oob = (addr >= TOTAL);
    r.sec = (s < 0) ? 4'd0 : 4'(s);
    return r;
  endfunction

  function automatic logic [W-1:0] exp_data(input req_t r, input logic [NS*W-1:0] bus);
    if (r.v && !r.oob) return bus[r.sec*W +: W];
    return '0;
  endfunction

  typedef struct { int addr; int sec; int sa; } dec_vec_t;
  dec_vec_t vt [9];

  initial begin
    req_t q, s1, s2;
    int addr;
    logic re, we, ice, oce;
    logic [NS*W-1:0] bus;

    vt[0] = '{512, 1, 0};    vt[1] = '{511, 0, 511};  vt[2] = '{1536, 3, 0};
    vt[3] = '{1791, 3, 255}; vt[4] = '{0, 0, 0};      vt[5] = '{1024, 2, 0};
    vt[6] = '{1535, 2, 511}; vt[7] = '{1800, -1, 0};  vt[8] = '{2047, -1, 0};

    reset = 1'b1; error_clear = 1'b0;
    a_address = '0; a_read_enable = 0; a_write = 0; a_in_clock_en = 1; a_out_clock_en = 1;
    b_address = '0; b_read_enable = 0; b_write = 0; b_in_clock_en = 1; b_out_clock_en = 1;
    sec_a_readdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0F0F};
    sec_b_readdata = {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444};

    #12;
    check("reset_a_valid", 64'(a_readdata_valid[DUT2]), 0);
    check("reset_a_data", 64'(a_readdata[DUT2]), 0);
    check("reset_a_oob", 64'(a_oob_error[DUT2]), 0);
    check("reset_b_valid", 64'(b_readdata_valid[DUT2]), 0);
    reset = 1'b0;
    tick();

    // Decode table, both ports, with input stage frozen so nothing is latched.
    a_in_clock_en = 0; b_in_clock_en = 0;
    for (int i = 0; i < 9; i++) begin
      logic [NS-1:0] en;
      en = (vt[i].sec < 0) ? '0 : NS'(1 << vt[i].sec);
      a_address = AW'(vt[i].addr); b_address = AW'(vt[i].addr);
      a_write = 1; a_read_enable = 0; b_write = 0; b_read_enable = 1;
      #1;
      check($sformatf("dec_a_write_%0d", vt[i].addr), 64'(sec_a_write[DUT2]), 64'(en));
      check($sformatf("dec_a_rd_gated_%0d", vt[i].addr), 64'(sec_a_read_enable[DUT2]), 0);
      check($sformatf("dec_b_read_%0d", vt[i].addr), 64'(sec_b_read_enable[DUT2]), 64'(en));
      check($sformatf("dec_b_wr_gated_%0d", vt[i].addr), 64'(sec_b_write[DUT2]), 0);
      if (vt[i].sec >= 0) begin
        check($sformatf("dec_a_secaddr_%0d", vt[i].addr),
              64'(sec_a_address[DUT2][vt[i].sec*SA +: SA]), 64'(vt[i].sa));
        check($sformatf("dec_b_secaddr_%0d", vt[i].addr),
              64'(sec_b_address[DUT2][vt[i].sec*SA +: SA]), 64'(vt[i].sa));
      end
      #1;
    end
    a_write = 0; b_read_enable = 0; a_in_clock_en = 1; b_in_clock_en = 1;
    tick();

    // Read of address 512 returns section 1 after two cycles.
    a_address = 11'd512; a_read_enable = 1;
    tick();
    a_read_enable = 0;
    check("rd512_not_yet", 64'(a_readdata_valid[DUT2]), 0);
    tick();
    check("rd512_valid", 64'(a_readdata_valid[DUT2]), 1);
    check("rd512_data", 64'(a_readdata[DUT2]), 64'h1111_1111);
    tick();
    check("rd512_done", 64'(a_readdata_valid[DUT2]), 0);

    // Out-of-range write, read and sticky-flag clearing.
    a_address = 11'd1800; a_write = 1;
    #1;
    check("oob_no_write_en", 64'(sec_a_write[DUT2]), 0);
    check("oob_flag_not_yet", 64'(a_oob_error[DUT2]), 0);
    tick();
    a_write = 0;
    check("oob_flag_set", 64'(a_oob_error[DUT2]), 1);
    a_read_enable = 1;
    tick();
    a_read_enable = 0;
    tick();
    check("oob_read_valid", 64'(a_readdata_valid[DUT2]), 1);
    check("oob_read_data", 64'(a_readdata[DUT2]), 0);
    error_clear = 1;
    tick();
    error_clear = 0;
    check("oob_cleared", 64'(a_oob_error[DUT2]), 0);
    error_clear = 1; a_write = 1;
    tick();
    error_clear = 0; a_write = 0;
    check("oob_set_beats_clear", 64'(a_oob_error[DUT2]), 1);
    error_clear = 1;
    tick();
    error_clear = 0;

    // Output-stage stall with a second read parked in the address stage.
    a_address = 11'd5; a_read_enable = 1;
    tick();
    a_address = 11'd1536;
    tick();
    a_read_enable = 0; a_in_clock_en = 0; a_out_clock_en = 0;
    #1;
    check("stall_valid_0", 64'(a_readdata_valid[DUT2]), 1);
    check("stall_data_0", 64'(a_readdata[DUT2]), 64'h0000_0F0F);
    for (int i = 1; i <= 3; i++) begin
      sec_a_readdata[31:0] = 32'hABC0_0000 + 32'(i);
      tick();
      check($sformatf("stall_valid_%0d", i), 64'(a_readdata_valid[DUT2]), 1);
      check($sformatf("stall_data_%0d", i), 64'(a_readdata[DUT2]), 64'(32'hABC0_0000 + 32'(i)));
    end
    a_out_clock_en = 1;
    tick();
    check("unstall_valid", 64'(a_readdata_valid[DUT2]), 1);
    check("unstall_data", 64'(a_readdata[DUT2]), 64'h3333_3333);
    a_in_clock_en = 1;
    tick();
    tick();
    check("unstall_drain", 64'(a_readdata_valid[DUT2]), 0);

    // Reset with reads in flight and the sticky flag set.
    a_address = 11'd1800; a_write = 1;
    tick();
    a_write = 0;
    check("rst_pre_oob", 64'(a_oob_error[DUT2]), 1);
    a_address = 11'd512; a_read_enable = 1;
    tick();
    tick();
    a_read_enable = 0;
    check("rst_pre_valid", 64'(a_readdata_valid[DUT2]), 1);
    reset = 1;
    #1;
    check("rst_valid", 64'(a_readdata_valid[DUT2]), 0);
    check("rst_data", 64'(a_readdata[DUT2]), 0);
    check("rst_oob", 64'(a_oob_error[DUT2]), 0);
    tick();
    check("rst_hold_valid", 64'(a_readdata_valid[DUT2]), 0);
    reset = 0;
    tick();
    check("rst_after_1", 64'(a_readdata_valid[DUT2]), 0);
    tick();
    check("rst_after_2", 64'(a_readdata_valid[DUT2]), 0);

    // Randomised concurrent traffic against the model, all three latencies at once.
    reset = 1;
    #2;
    reset = 0;
    for (int g = 0; g < 3; g++)
      for (int p = 0; p < 2; p++) begin
        st_a[g][p] = '0; st_d[g][p] = '0; err_m[g][p] = 1'b0;
      end
    tick();
    for (int c = 0; c < 100; c++) begin
      a_address = AW'($urandom_range(0, 511));
      b_address = ($urandom_range(0, 15) == 0) ? AW'(1800 + $urandom_range(0, 200))
                                               : AW'($urandom_range(1536, 1791));
      a_read_enable = ($urandom_range(0, 7) != 0); b_read_enable = ($urandom_range(0, 7) != 0);
      a_write = ($urandom_range(0, 3) == 0);       b_write = ($urandom_range(0, 3) == 0);
      a_in_clock_en = ($urandom_range(0, 3) != 0); a_out_clock_en = ($urandom_range(0, 3) != 0);
      b_in_clock_en = ($urandom_range(0, 3) != 0); b_out_clock_en = ($urandom_range(0, 3) != 0);
      error_clear = ($urandom_range(0, 7) == 0);
      sec_a_readdata = {$urandom, $urandom, $urandom, $urandom};
      sec_b_readdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      for (int g = 0; g < 3; g++)
        for (int p = 0; p < 2; p++) begin
          addr = (p == 0) ? int'(a_address) : int'(b_address);
          re   = (p == 0) ? a_read_enable : b_read_enable;
          bus  = (p == 0) ? sec_a_readdata : sec_b_readdata;
          q  = make_req(addr, re);
          s1 = (g >= 1) ? st_a[g][p] : q;
          s2 = (g == 2) ? st_d[g][p] : s1;
          check($sformatf("rnd_c%0d_L%0d_p%0d_data", c, g, p),
                64'((p == 0) ? a_readdata[g] : b_readdata[g]), 64'(exp_data(s2, bus)));
          check($sformatf("rnd_c%0d_L%0d_p%0d_valid", c, g, p),
                64'((p == 0) ? a_readdata_valid[g] : b_readdata_valid[g]), 64'(s2.v));
          check($sformatf("rnd_c%0d_L%0d_p%0d_oob", c, g, p),
                64'((p == 0) ? a_oob_error[g] : b_oob_error[g]), 64'(err_m[g][p]));
        end
      @(posedge clock);
      for (int g = 0; g < 3; g++)
        for (int p = 0; p < 2; p++) begin
          addr = (p == 0) ? int'(a_address) : int'(b_address);
          re   = (p == 0) ? a_read_enable : b_read_enable;
          we   = (p == 0) ? a_write : b_write;
          ice  = (p == 0) ? a_in_clock_en : b_in_clock_en;
          oce  = (p == 0) ? a_out_clock_en : b_out_clock_en;
          q  = make_req(addr, re);
          s1 = (g >= 1) ? st_a[g][p] : q;
          if (g == 2 && oce) st_d[g][p] = s1;
          if (g >= 1 && ice) st_a[g][p] = q;
          if (ice && (we || re) && q.oob) err_m[g][p] = 1'b1;
          else if (error_clear) err_m[g][p] = 1'b0;
        end
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
